sample_buffer_reader: RTL

// Read-side counterpart to the ADC capture path. Once the sampler finishes filling the per-channel
// 8x512 sample RAMs, this block walks every address and streams frames out on a byte-wide

---
 rtl/sample_buffer_reader.sv | 96 +++++++++
 1 files changed

// File: rtl/sample_buffer_reader.sv
// rtl/sample_buffer_reader.sv - drains the per-channel sample RAMs as a byte stream after capture
// Walks every address once per capture; frames are ch0..ch(NCH-1) per address, no cross-address overlap.
module sample_buffer_reader #(
   parameter int NCH    = 4,
   parameter int AW     = 9,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             capture_done,
   output logic [AW-1:0]    rd_addr,
   input  logic [NCH*8-1:0] ram_q,
   output logic [7:0]       out_data,
   output logic [2:0]       out_chnl,
   output logic             out_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             rearm
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_EMIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [AW-1:0] LAST_ADDR = '1;
   localparam logic [2:0]    LAST_CH   = 3'(NCH - 1);
   localparam logic [1:0]    WAIT_LOAD = 2'(RD_LAT - 1);

   logic [2:0] state;
   logic [2:0] chan;
   logic [1:0] wcnt;
   logic [7:0] frame [8];
   logic       emit;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state   <= S_IDLE;
         rd_addr <= '0;
         chan    <= 3'd0;
         wcnt    <= 2'd0;
         rearm   <= 1'b0;
         for (int k = 0; k < 8; k++) frame[k] <= 8'h00;
      end else begin
         rearm <= 1'b0;
         case (state)
            S_IDLE: if (capture_done) begin
               state   <= S_ADDR;
               rd_addr <= '0;
               chan    <= 3'd0;
            end
            S_ADDR: begin
               state <= S_WAIT;
               wcnt  <= WAIT_LOAD;
            end
            // ram_q is valid for the current address once the countdown reaches zero
            S_WAIT: if (wcnt == 2'd0) begin
               for (int k = 0; k < NCH; k++) frame[k] <= ram_q[8*k +: 8];
               state <= S_EMIT;
            end else begin
               wcnt <= wcnt - 2'd1;
            end
            S_EMIT: if (out_ready) begin
               if (chan == LAST_CH) begin
                  chan <= 3'd0;
                  if (rd_addr == LAST_ADDR) begin
                     state <= S_DONE;
                     rearm <= 1'b1;
                  end else begin
                     rd_addr <= rd_addr + AW'(1);
                     state   <= S_ADDR;
                  end
               end else begin
                  chan <= chan + 3'd1;
               end
            end
            // a capture_done still high from this buffer must not trigger a second read
            S_DONE: if (!capture_done) begin
               state   <= S_IDLE;
               rd_addr <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign emit      = (state == S_EMIT);
   assign out_valid = emit;
   assign out_data  = emit ? frame[chan] : 8'h00;
   assign out_chnl  = emit ? chan : 3'd0;
   assign out_last  = emit && (rd_addr == LAST_ADDR) && (chan == LAST_CH);
   assign busy      = (state == S_ADDR) || (state == S_WAIT) || (state == S_EMIT);

endmodule
